rtc_tick_gen: RTL

//  Consumes the QD (divide-by-16) output of the upstream 4-stage ripple counter
//  (74393 stage) and turns its wrap-arounds into synchronous timer ticks.

---
 rtl/rtc_tick_gen_if.sv | 34 +++
 rtl/rtc_tick_gen.sv | 119 +++++++++++
 2 files changed

// File: rtl/rtc_tick_gen_if.sv
// rtl/rtc_tick_gen_if.sv - host-side bundle for the RTC tick generator
// Ports (seen from the tick generator, slave modport):
//   qd_in      in   QD of the upstream ripple counter, asynchronous
//   enable     in   1 = overflow events are counted
//   div_load   in   strobe: load div_value into reload register and counter
//   div_value  in   prescaler reload value, tick every div_value+1 overflows
//   irq_ack    in   strobe: acknowledge the pending interrupt
//   tick       out  1-cycle pulse on prescaler terminal count
//   irq        out  level interrupt request, held until acknowledged
//   overrun    out  a tick arrived while irq was already pending
//   div_count  out  current prescaler down-counter value
interface rtc_tick_gen_if #(
    parameter int DIV_WIDTH = 8
);
    logic                 qd_in;
    logic                 enable;
    logic                 div_load;
    logic [DIV_WIDTH-1:0] div_value;
    logic                 irq_ack;
    logic                 tick;
    logic                 irq;
    logic                 overrun;
    logic [DIV_WIDTH-1:0] div_count;

    modport master (
        output qd_in, enable, div_load, div_value, irq_ack,
        input  tick, irq, overrun, div_count
    );

    modport slave (
        input  qd_in, enable, div_load, div_value, irq_ack,
        output tick, irq, overrun, div_count
    );
endinterface

// File: rtl/rtc_tick_gen.sv
// rtl/rtc_tick_gen.sv - ripple-counter overflow to prescaled tick and latched irq
// Ports:
//   clk    in     system clock, rising edge
//   rst_n  in     asynchronous reset, active low
//   bus    slave  rtc_tick_gen_if (qd_in, enable, div_load, div_value, irq_ack
//                 in; tick, irq, overrun, div_count out)
module rtc_tick_gen #(
    parameter int SYNC_STAGES = 2,
    parameter int DIV_WIDTH   = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    rtc_tick_gen_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        OVR  = 2'd2
    } irq_state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   ovf_q;
    logic [DIV_WIDTH-1:0]   reload_q;
    logic [DIV_WIDTH-1:0]   count_q;
    logic                   tick_q;
    irq_state_t             state_q;
    irq_state_t             state_d;
    logic                   irq_d;
    logic                   overrun_d;

    // Synchroniser plus edge register. The overflow strobe is itself a flop so
    // a QD fall reaches ovf_q SYNC_STAGES+1 edges later. Only a 1->0 transition
    // of the synced value counts; the reset value of 0 guarantees that a QD
    // already high at reset release is seen as a rising edge and ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.qd_in};
            prev_q <= sync_q[SYNC_STAGES-1];
            ovf_q  <= prev_q & ~sync_q[SYNC_STAGES-1];
        end
    end

    // Prescaler: a load always wins, even over a coincident overflow, so
    // software reprogramming never emits a spurious tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reload_q <= '0;
            count_q  <= '0;
            tick_q   <= 1'b0;
        end else if (bus.div_load) begin
            reload_q <= bus.div_value;
            count_q  <= bus.div_value;
            tick_q   <= 1'b0;
        end else if (ovf_q && bus.enable) begin
            if (count_q == '0) begin
                tick_q  <= 1'b1;
                count_q <= reload_q;
            end else begin
                tick_q  <= 1'b0;
                count_q <= count_q - 1'b1;
            end
        end else begin
            tick_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A tick coinciding with an acknowledge consumes the old request and
    // leaves the new one pending, which also clears any overrun.
    always_comb begin
        state_d   = state_q;
        irq_d     = 1'b0;
        overrun_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (tick_q) begin
                    state_d = PEND;
                end
            end
            PEND: begin
                irq_d = 1'b1;
                if (tick_q && !bus.irq_ack) begin
                    state_d = OVR;
                end else if (!tick_q && bus.irq_ack) begin
                    state_d = IDLE;
                end
            end
            OVR: begin
                irq_d     = 1'b1;
                overrun_d = 1'b1;
                if (bus.irq_ack) begin
                    state_d = tick_q ? PEND : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.tick      = tick_q;
    assign bus.irq       = irq_d;
    assign bus.overrun   = overrun_d;
    assign bus.div_count = count_q;

endmodule
